sim_run_ctrl: RTL and testbench
===============================

SIM_RUN_CTRL -- requirements
Module: sim_run_ctrl

Interface
REQ-001 Parameter RST_CYCLES, default 25: number of clk cycles the CPU reset is held after rst_n releases.
REQ-002 Parameter TIMEOUT_CYCLES, default 150000000: run-cycle budget before a forced stop.
REQ-003 Parameter CNT_W, default 32: width of the cycle counter; TIMEOUT_CYCLES SHALL fit in CNT_W bits.
REQ-004 Parameter ADDR_W, default 32: width of the monitored I/O address.
REQ-005 Parameter CHAR_ADDR, default 32'h30000: I/O address of console character writes.
REQ-006 Parameter HALT_ADDR, default 32'h30004: I/O address of the program-halt write.
REQ-007 Parameter FIFO_DEPTH, default 16 (power of two, >=2): console character buffer depth.
REQ-008 clk  in  1  single clock; all state updates on rising edge.
REQ-009 rst_n  in  1  synchronous, active-low reset.
REQ-010 io_we  in  1  CPU I/O write strobe, one transfer per cycle it is high.
REQ-011 io_addr  in  ADDR_W  CPU I/O write address.
REQ-012 io_data  in  8  CPU I/O write data byte.
REQ-013 cpu_rst  out  1  active-high reset driven to the CPU.
REQ-014 running  out  1  high while in RUN.
REQ-015 done  out  1  high in HALTED or TIMEOUT; sticky until rst_n.
REQ-016 timed_out  out  1  high only in TIMEOUT.
REQ-017 exit_code  out  8  io_data captured by the halt write.
REQ-018 cycle_cnt  out  CNT_W  cycles spent in RUN.
REQ-019 ch_valid  out  1  console FIFO non-empty.
REQ-020 ch_data  out  8  FIFO head byte, valid when ch_valid.
REQ-021 ch_ready  in  1  consumer pops head when ch_valid && ch_ready.
REQ-022 ch_dropped  out  1  sticky: a character was lost to a full FIFO.

Function
REQ-023 States SHALL be HOLD, RUN, HALTED, TIMEOUT; cpu_rst=1 in HOLD, 0 otherwise.
REQ-024 HOLD SHALL count RST_CYCLES cycles then enter RUN; cpu_rst is high for exactly RST_CYCLES cycles after the first cycle with rst_n=1.
REQ-025 In RUN cycle_cnt SHALL increment by 1 each cycle; it is frozen in HOLD, HALTED, TIMEOUT.
REQ-026 RUN -> HALTED on io_we && io_addr==HALT_ADDR; exit_code <= io_data the same edge.
REQ-027 RUN -> TIMEOUT when cycle_cnt reaches TIMEOUT_CYCLES-1 without a halt write; cycle_cnt ends at TIMEOUT_CYCLES.
REQ-028 Halt write and timeout in the same cycle: HALTED wins, timed_out=0.
REQ-029 HALTED and TIMEOUT are terminal; only rst_n=0 exits them.
REQ-030 io_we SHALL be ignored outside RUN.
REQ-031 In RUN, io_we && io_addr==CHAR_ADDR SHALL push io_data into the FIFO; other addresses are ignored.
REQ-032 FIFO full with no pop that cycle: push discarded, ch_dropped set; push and pop in the same cycle when full SHALL both succeed.
REQ-033 Pop while empty SHALL be ignored; pointers wrap modulo FIFO_DEPTH; occupancy counter of log2(FIFO_DEPTH)+1 bits.
REQ-034 FIFO SHALL keep draining in HALTED and TIMEOUT.
REQ-035 Push-to-ch_valid latency SHALL be 1 cycle; ch_data SHALL be stable while ch_valid && !ch_ready.

Reset
REQ-036 rst_n=0 at a clock edge SHALL force: state HOLD, hold counter 0, cpu_rst=1, running=0, done=0, timed_out=0, exit_code=0, cycle_cnt=0, FIFO empty, ch_valid=0, ch_dropped=0.
REQ-037 Reset mid-RUN or in a terminal state SHALL discard buffered characters and restart the full HOLD sequence.

Verification
REQ-038 rst_n low 3 cycles then high, RST_CYCLES=25 -> cpu_rst high for exactly 25 cycles after release, running rises the next cycle.
REQ-039 RUN, write 0x41,0x42 to CHAR_ADDR, ch_ready=1 -> ch_data 0x41 then 0x42, one cycle after each push; ch_dropped=0.
REQ-040 FIFO_DEPTH=4, ch_ready=0, 5 char writes -> 4 bytes retained in order, ch_dropped=1; then push+pop same cycle when full -> both succeed.
REQ-041 Halt write data 0x07 at RUN cycle 100 -> done=1, timed_out=0, exit_code=0x07, cycle_cnt holds 100 (or 101 per count alignment, checked as fixed) thereafter.
REQ-042 TIMEOUT_CYCLES=50, no halt -> timed_out=1, done=1, cycle_cnt=50; halt write on the final RUN cycle -> HALTED, timed_out=0.
REQ-043 rst_n low while HALTED with 3 bytes buffered -> all outputs at reset values, FIFO empty, HOLD restarts.

Source files
------------

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the CPU in reset, then supervises its run until a
// halt write or cycle budget expiry, buffering console characters in a small FIFO.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_HOLD    | cpu_rst asserted, counting RST_CYCLES cycles
// S_RUN     | CPU running, cycle_cnt advancing, I/O writes decoded
// S_HALTED  | program wrote the halt address; exit_code captured (terminal)
// S_TIMEOUT | cycle budget exhausted without a halt write (terminal)
module sim_run_ctrl #(
   parameter int                RST_CYCLES     = 25,
   parameter int                TIMEOUT_CYCLES = 150000000,
   parameter int                CNT_W          = 32,
   parameter int                ADDR_W         = 32,
   parameter logic [ADDR_W-1:0] CHAR_ADDR      = ADDR_W'(32'h30000),
   parameter logic [ADDR_W-1:0] HALT_ADDR      = ADDR_W'(32'h30004),
   parameter int                FIFO_DEPTH     = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              io_we,
   input  logic [ADDR_W-1:0] io_addr,
   input  logic [7:0]        io_data,
   output logic              cpu_rst,
   output logic              running,
   output logic              done,
   output logic              timed_out,
   output logic [7:0]        exit_code,
   output logic [CNT_W-1:0]  cycle_cnt,
   output logic              ch_valid,
   output logic [7:0]        ch_data,
   input  logic              ch_ready,
   output logic              ch_dropped
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int HW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
   localparam logic [HW-1:0]    HOLD_LAST = HW'(RST_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TIMEOUT_CYCLES - 1);
   localparam logic [AW:0]      DEPTH_C   = (AW + 1)'(FIFO_DEPTH);

   localparam logic [1:0] S_HOLD    = 2'd0;
   localparam logic [1:0] S_RUN     = 2'd1;
   localparam logic [1:0] S_HALTED  = 2'd2;
   localparam logic [1:0] S_TIMEOUT = 2'd3;

   logic [1:0]       r_state;
   logic [HW-1:0]    r_hold_cnt;
   logic [CNT_W-1:0] r_cycle_cnt;
   logic [7:0]       r_exit_code;

   logic [7:0]       r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             r_dropped;

   logic w_in_run;
   logic w_halt_wr;
   logic w_char_wr;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_in_run  = (r_state == S_RUN);
   assign w_halt_wr = w_in_run && io_we && (io_addr == HALT_ADDR);
   assign w_char_wr = w_in_run && io_we && (io_addr == CHAR_ADDR);
   assign w_full    = (r_count == DEPTH_C);
   assign w_pop     = (r_count != '0) && ch_ready;
   // A pop frees the slot in the same edge, so a full FIFO still accepts the push.
   assign w_push    = w_char_wr && (!w_full || w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_HOLD;
         r_hold_cnt  <= '0;
         r_cycle_cnt <= '0;
         r_exit_code <= 8'h00;
      end else begin
         case (r_state)
            S_HOLD: begin
               if (r_hold_cnt == HOLD_LAST) r_state <= S_RUN;
               else                         r_hold_cnt <= r_hold_cnt + HW'(1);
            end
            S_RUN: begin
               r_cycle_cnt <= r_cycle_cnt + CNT_W'(1);
               // Halt write takes priority over a coincident budget expiry.
               if (w_halt_wr) begin
                  r_state     <= S_HALTED;
                  r_exit_code <= io_data;
               end else if (r_cycle_cnt == CNT_LAST) begin
                  r_state <= S_TIMEOUT;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_dropped <= 1'b0;
      end else begin
         if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
         if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW + 1)'(1);
            2'b01:   r_count <= r_count - (AW + 1)'(1);
            default: ;
         endcase
         if (w_char_wr && !w_push) r_dropped <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr] <= io_data;
   end

   assign cpu_rst    = (r_state == S_HOLD);
   assign running    = w_in_run;
   assign done       = (r_state == S_HALTED) || (r_state == S_TIMEOUT);
   assign timed_out  = (r_state == S_TIMEOUT);
   assign exit_code  = r_exit_code;
   assign cycle_cnt  = r_cycle_cnt;
   assign ch_valid   = (r_count != '0);
   assign ch_data    = r_mem[r_rd_ptr];
   assign ch_dropped = r_dropped;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: two instances (small FIFO / short budget, and a larger one)
// share stimulus; a per-cycle model plus literal expectations check both.
module tb_sim_run_ctrl;

   localparam logic [31:0] CHAR  = 32'h30000;
   localparam logic [31:0] HALT  = 32'h30004;
   localparam logic [31:0] OTHER = 32'h30008;

   logic        clk;
   logic        rst_n;
   logic        io_we;
   logic [31:0] io_addr;
   logic [7:0]  io_data;
   logic        ch_ready;

   logic        a_cpu_rst, a_running, a_done, a_timed_out, a_ch_valid, a_ch_dropped;
   logic [7:0]  a_exit_code, a_ch_data;
   logic [31:0] a_cycle_cnt;
   logic        b_cpu_rst, b_running, b_done, b_timed_out, b_ch_valid, b_ch_dropped;
   logic [7:0]  b_exit_code, b_ch_data;
   logic [15:0] b_cycle_cnt;

   int n_checks = 0;
   int n_pass   = 0;

   sim_run_ctrl #(
      .RST_CYCLES(25), .TIMEOUT_CYCLES(50), .CNT_W(32), .ADDR_W(32),
      .CHAR_ADDR(32'h30000), .HALT_ADDR(32'h30004), .FIFO_DEPTH(4)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_addr(io_addr), .io_data(io_data),
      .cpu_rst(a_cpu_rst), .running(a_running), .done(a_done), .timed_out(a_timed_out),
      .exit_code(a_exit_code), .cycle_cnt(a_cycle_cnt), .ch_valid(a_ch_valid),
      .ch_data(a_ch_data), .ch_ready(ch_ready), .ch_dropped(a_ch_dropped)
   );

   sim_run_ctrl #(
      .RST_CYCLES(25), .TIMEOUT_CYCLES(200), .CNT_W(16), .ADDR_W(32),
      .CHAR_ADDR(32'h30000), .HALT_ADDR(32'h30004), .FIFO_DEPTH(16)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .io_we(io_we), .io_addr(io_addr), .io_data(io_data),
      .cpu_rst(b_cpu_rst), .running(b_running), .done(b_done), .timed_out(b_timed_out),
      .exit_code(b_exit_code), .cycle_cnt(b_cycle_cnt), .ch_valid(b_ch_valid),
      .ch_data(b_ch_data), .ch_ready(ch_ready), .ch_dropped(b_ch_dropped)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic int p_rst(input int d);
      return 25 + 0 * d;
   endfunction
   function automatic int p_to(input int d);
      return (d == 0) ? 50 : 200;
   endfunction
   function automatic int p_depth(input int d);
      return (d == 0) ? 4 : 16;
   endfunction

   // Model: cycles since release, RUN-cycle tally, terminal flags and a plain byte list.
   int         m_rel  [2];
   int         m_runs [2];
   int         m_n    [2];
   bit         m_halt [2];
   bit         m_tout [2];
   bit         m_drop [2];
   logic [7:0] m_exit [2];
   logic [7:0] m_buf  [2][64];
   bit         m_valid = 1'b0;
   bit         mv_run, mv_pop, mv_full;

   always @(posedge clk) begin
      for (int d = 0; d < 2; d++) begin
         if (!rst_n) begin
            m_rel[d]  = 0;
            m_runs[d] = 0;
            m_n[d]    = 0;
            m_halt[d] = 1'b0;
            m_tout[d] = 1'b0;
            m_drop[d] = 1'b0;
            m_exit[d] = 8'h00;
            m_valid   = 1'b1;
         end else begin
            mv_run  = (m_rel[d] >= p_rst(d)) && !m_halt[d] && !m_tout[d];
            mv_pop  = (m_n[d] > 0) && ch_ready;
            mv_full = (m_n[d] == p_depth(d));
            if (mv_pop) begin
               for (int k = 0; k < 63; k++) m_buf[d][k] = m_buf[d][k+1];
               m_n[d]--;
            end
            if (mv_run && io_we && io_addr == CHAR) begin
               if (!mv_full || mv_pop) begin
                  m_buf[d][m_n[d]] = io_data;
                  m_n[d]++;
               end else begin
                  m_drop[d] = 1'b1;
               end
            end
            if (mv_run) begin
               m_runs[d]++;
               if (io_we && io_addr == HALT) begin
                  m_halt[d] = 1'b1;
                  m_exit[d] = io_data;
               end else if (m_runs[d] == p_to(d)) begin
                  m_tout[d] = 1'b1;
               end
            end
            if (m_rel[d] < p_rst(d)) m_rel[d]++;
         end
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
   endtask

   task automatic cmp_one(input int d, input logic cr, input logic rn, input logic dn,
                          input logic to, input logic [7:0] ex, input logic [31:0] cc,
                          input logic cv, input logic [7:0] cd, input logic dr);
      logic e_hold, e_end;
      e_hold = (m_rel[d] < p_rst(d));
      e_end  = m_halt[d] || m_tout[d];
      chk($sformatf("dut%0d cpu_rst", d),    32'(cr), 32'(e_hold));
      chk($sformatf("dut%0d running", d),    32'(rn), 32'(!e_hold && !e_end));
      chk($sformatf("dut%0d done", d),       32'(dn), 32'(e_end));
      chk($sformatf("dut%0d timed_out", d),  32'(to), 32'(m_tout[d]));
      chk($sformatf("dut%0d exit_code", d),  32'(ex), 32'(m_exit[d]));
      chk($sformatf("dut%0d cycle_cnt", d),  cc,      32'(m_runs[d]));
      chk($sformatf("dut%0d ch_valid", d),   32'(cv), 32'(m_n[d] > 0));
      if (m_n[d] > 0) chk($sformatf("dut%0d ch_data", d), 32'(cd), 32'(m_buf[d][0]));
      chk($sformatf("dut%0d ch_dropped", d), 32'(dr), 32'(m_drop[d]));
   endtask

   task automatic tick();
      @(negedge clk);
      if (m_valid) begin
         cmp_one(0, a_cpu_rst, a_running, a_done, a_timed_out, a_exit_code, a_cycle_cnt,
                 a_ch_valid, a_ch_data, a_ch_dropped);
         cmp_one(1, b_cpu_rst, b_running, b_done, b_timed_out, b_exit_code,
                 32'(b_cycle_cnt), b_ch_valid, b_ch_data, b_ch_dropped);
      end
   endtask

   task automatic wr(input logic [31:0] addr, input logic [7:0] data);
      io_we   = 1'b1;
      io_addr = addr;
      io_data = data;
      tick();
      io_we   = 1'b0;
   endtask

   task automatic hold_seq(input string tag);
      int n;
      io_we   = 1'b1;
      io_addr = CHAR;
      io_data = 8'hEE;
      rst_n   = 1'b1;
      n       = 1;
      while (a_cpu_rst && n < 100) begin
         tick();
         if (a_cpu_rst) n++;
      end
      io_we = 1'b0;
      chk({tag, " cpu_rst cycles"}, 32'(n), 32'd25);
      chk({tag, " a running"},      32'(a_running), 32'd1);
      chk({tag, " b running"},      32'(b_running), 32'd1);
      chk({tag, " cnt at run"},     a_cycle_cnt, 32'd0);
      chk({tag, " no hold push"},   32'(a_ch_valid), 32'd0);
   endtask

   task automatic reset_vals(input string tag);
      chk({tag, " a cpu_rst"},   32'(a_cpu_rst), 32'd1);
      chk({tag, " a running"},   32'(a_running), 32'd0);
      chk({tag, " a done"},      32'(a_done), 32'd0);
      chk({tag, " a timed_out"}, 32'(a_timed_out), 32'd0);
      chk({tag, " a exit"},      32'(a_exit_code), 32'd0);
      chk({tag, " a cnt"},       a_cycle_cnt, 32'd0);
      chk({tag, " a ch_valid"},  32'(a_ch_valid), 32'd0);
      chk({tag, " a dropped"},   32'(a_ch_dropped), 32'd0);
      chk({tag, " b done"},      32'(b_done), 32'd0);
      chk({tag, " b ch_valid"},  32'(b_ch_valid), 32'd0);
   endtask

   logic [7:0] got_a [8];
   logic [7:0] got_b [8];
   logic [7:0] exp_a [4];
   logic [7:0] exp_b [5];
   int         na, nb;

   initial begin
      rst_n    = 1'b0;
      io_we    = 1'b0;
      io_addr  = 32'h0;
      io_data  = 8'h00;
      ch_ready = 1'b0;
      exp_a    = '{8'h11, 8'h12, 8'h13, 8'h15};
      exp_b    = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15};

      repeat (3) tick();
      reset_vals("por");
      hold_seq("hold1");

      // Console bytes with a ready consumer: each appears one cycle after its push.
      ch_ready = 1'b1;
      wr(CHAR, 8'h41);
      chk("c1 a valid", 32'(a_ch_valid), 32'd1);
      chk("c1 a data",  32'(a_ch_data), 32'h41);
      chk("c1 b data",  32'(b_ch_data), 32'h41);
      wr(CHAR, 8'h42);
      chk("c2 a data",  32'(a_ch_data), 32'h42);
      chk("c2 b data",  32'(b_ch_data), 32'h42);
      tick();
      chk("c3 a empty", 32'(a_ch_valid), 32'd0);
      chk("c3 dropped", 32'(a_ch_dropped), 32'd0);
      ch_ready = 1'b0;
      wr(OTHER, 8'h99);
      chk("other addr ignored", 32'(a_ch_valid), 32'd0);

      // Overfill the depth-4 FIFO, then push and pop together while full.
      for (int i = 0; i < 5; i++) wr(CHAR, 8'(8'h10 + i));
      chk("full a dropped", 32'(a_ch_dropped), 32'd1);
      chk("full b dropped", 32'(b_ch_dropped), 32'd0);
      chk("full a head",    32'(a_ch_data), 32'h10);
      ch_ready = 1'b1;
      wr(CHAR, 8'h15);
      ch_ready = 1'b0;
      chk("pushpop a head", 32'(a_ch_data), 32'h11);
      chk("pushpop a valid", 32'(a_ch_valid), 32'd1);

      for (int i = 0; i < 100 && !a_done; i++) tick();
      chk("to a timed_out", 32'(a_timed_out), 32'd1);
      chk("to a done",      32'(a_done), 32'd1);
      chk("to a cnt",       a_cycle_cnt, 32'd50);
      chk("to b running",   32'(b_running), 32'd1);

      // Drain: dut0 is now in TIMEOUT and must still deliver its bytes.
      ch_ready = 1'b1;
      na = 0;
      nb = 0;
      for (int i = 0; i < 8; i++) begin
         if (a_ch_valid) begin got_a[na] = a_ch_data; na++; end
         if (b_ch_valid) begin got_b[nb] = b_ch_data; nb++; end
         tick();
      end
      ch_ready = 1'b0;
      chk("drain a count", 32'(na), 32'd4);
      chk("drain b count", 32'(nb), 32'd5);
      for (int i = 0; i < 4; i++) chk($sformatf("drain a[%0d]", i), 32'(got_a[i]), 32'(exp_a[i]));
      for (int i = 0; i < 5; i++) chk($sformatf("drain b[%0d]", i), 32'(got_b[i]), 32'(exp_b[i]));

      for (int i = 0; i < 200 && b_cycle_cnt != 16'd100; i++) tick();
      chk("b reached 100", 32'(b_cycle_cnt), 32'd100);
      wr(HALT, 8'h07);
      chk("halt b done",  32'(b_done), 32'd1);
      chk("halt b to",    32'(b_timed_out), 32'd0);
      chk("halt b exit",  32'(b_exit_code), 32'h07);
      chk("halt b cnt",   32'(b_cycle_cnt), 32'd101);
      chk("halt a exit",  32'(a_exit_code), 32'd0);
      wr(CHAR, 8'h55);
      repeat (4) tick();
      chk("hold b cnt",     32'(b_cycle_cnt), 32'd101);
      chk("terminal no push", 32'(b_ch_valid), 32'd0);

      rst_n = 1'b0;
      repeat (2) tick();
      reset_vals("rst2");
      hold_seq("hold2");

      // Buffer three bytes, then halt on the last RUN cycle of dut0.
      for (int i = 0; i < 3; i++) wr(CHAR, 8'(8'h61 + i));
      for (int i = 0; i < 100 && a_cycle_cnt != 32'd49; i++) tick();
      chk("a reached 49", a_cycle_cnt, 32'd49);
      wr(HALT, 8'h5A);
      chk("last a done",  32'(a_done), 32'd1);
      chk("last a to",    32'(a_timed_out), 32'd0);
      chk("last a exit",  32'(a_exit_code), 32'h5A);
      chk("last a cnt",   a_cycle_cnt, 32'd50);
      chk("last a head",  32'(a_ch_data), 32'h61);
      repeat (2) tick();
      chk("last a sticky", 32'(a_timed_out), 32'd0);

      rst_n = 1'b0;
      tick();
      reset_vals("rst3");
      tick();
      hold_seq("hold3");

      for (int i = 0; i < 2; i++) wr(CHAR, 8'(8'h71 + i));
      chk("midrun a valid", 32'(a_ch_valid), 32'd1);
      rst_n = 1'b0;
      tick();
      reset_vals("rst4");
      rst_n = 1'b1;
      repeat (5) tick();
      chk("rst4 hold", 32'(a_cpu_rst), 32'd1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
